// File: rtl/paddle_motion_ctrl_if.sv
// Purpose: bundles the control/ball inputs and paddle outputs of one paddle controller.
// Latency: none; a pure signal bundle.
// Backpressure: none; all signals are level or single-cycle pulses with no handshake.
// Ports: master drives game inputs and reads paddle state; slave is the controller itself.
interface paddle_motion_ctrl_if #(
    parameter int POS_W = 10
);
    logic             reset_game;   // synchronous recentre
    logic [1:0]       mode_choice;  // 0/3 hold, 1 AI, 2 human
    logic             move_up;      // player up, synchronised level
    logic             move_down;    // player down, synchronised level
    logic [POS_W-1:0] sq_ypos;      // ball top y
    logic             sq_xveldir;   // ball horizontal direction
    logic             sq_missed;    // ball reached a side wall (pulse)
    logic [POS_W-1:0] x_pos;        // constant paddle x
    logic [POS_W-1:0] y_pos;        // paddle top y
    logic [1:0]       tier;         // current speed tier
    logic             moving;       // high in the cycle y_pos changed

    modport master (
        output reset_game, mode_choice, move_up, move_down, sq_ypos, sq_xveldir, sq_missed,
        input  x_pos, y_pos, tier, moving
    );

    modport slave (
        input  reset_game, mode_choice, move_up, move_down, sq_ypos, sq_xveldir, sq_missed,
        output x_pos, y_pos, tier, moving
    );
endinterface

// File: rtl/paddle_motion_ctrl.sv
// Purpose: one paddle's vertical motion from buttons (with speed ramp), an AI tracker, or hold.
// Latency: a step lands period(tier) cycles after a move request begins; outputs are registered.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
// Ports: clk_0 clock, rst async active-low reset, pif (slave) carries game inputs and paddle outputs.
module paddle_motion_ctrl #(
    parameter int POS_W       = 10,
    parameter int V_VIDEO     = 480,
    parameter int PDL_HEIGHT  = 96,
    parameter int START_X     = 24,
    parameter int CLK_HZ      = 25_175_000,
    parameter int BASE_SPEED  = 300,
    parameter int NUM_TIERS   = 3,
    parameter int ACCEL_PIX   = 16,
    parameter int AI_REACT    = 12_587_500,
    parameter int AI_DEADBAND = 4,
    parameter bit TOWARD_DIR  = 1'b0
) (
    input  logic                 clk_0,
    input  logic                 rst,
    paddle_motion_ctrl_if.slave  pif
);
    localparam int PERIOD0   = CLK_HZ / BASE_SPEED;
    localparam int CNT_W     = $clog2(PERIOD0 + 1);
    localparam int REACT_W   = $clog2(AI_REACT + 1);
    localparam int RUN_W     = $clog2(ACCEL_PIX + 1);
    localparam int TGT_W     = POS_W + 2;
    localparam int BALL_HALF = 4;

    localparam logic [POS_W-1:0]   CENTRE     = POS_W'(V_VIDEO / 2 - PDL_HEIGHT / 2);
    localparam logic [POS_W-1:0]   Y_MAX      = POS_W'(V_VIDEO - PDL_HEIGHT);
    localparam logic [1:0]         TIER_MAX   = 2'(NUM_TIERS - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(ACCEL_PIX - 1);
    localparam logic [REACT_W-1:0] REACT_LAST = REACT_W'(AI_REACT - 1);
    localparam logic signed [TGT_W-1:0] TGT_OFS = TGT_W'(BALL_HALF - PDL_HEIGHT / 2);
    localparam logic signed [TGT_W-1:0] Y_MAX_S = TGT_W'(V_VIDEO - PDL_HEIGHT);
    localparam logic signed [TGT_W-1:0] DB_S    = TGT_W'(AI_DEADBAND);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUMAN,
        ST_AI_WAIT,
        ST_AI_TRACK
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [POS_W-1:0]   y_q;
    logic [1:0]         tier_q;
    logic [CNT_W-1:0]   step_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic [REACT_W-1:0] react_cnt;
    logic               moving_q;
    logic               prev_req;
    logic               prev_up;

    logic                    toward;
    logic signed [TGT_W-1:0] tgt_raw, tgt, err, abs_err;
    logic                    req, req_up, restart, fire, at_limit;
    logic [CNT_W-1:0]        cnt_base, step_last;
    logic [RUN_W-1:0]        run_base, run_upd;
    logic [1:0]              tier_eff, tier_upd;
    logic [POS_W-1:0]        y_step;
    int                      period_i;

    assign toward = (pif.sq_xveldir == TOWARD_DIR);

    always_comb begin
        nxt_state = state;
        case (pif.mode_choice)
            2'd1: begin
                if (pif.sq_missed || state == ST_IDLE || state == ST_HUMAN)
                    nxt_state = ST_AI_WAIT;
                else if (state == ST_AI_WAIT && toward && react_cnt == REACT_LAST)
                    nxt_state = ST_AI_TRACK;
                else if (state == ST_AI_TRACK && !toward)
                    nxt_state = ST_AI_WAIT;
            end
            2'd2:    nxt_state = ST_HUMAN;
            default: nxt_state = ST_IDLE;
        endcase
    end

    // AI target: centre the paddle on the ball centre, clamped to the legal range.
    always_comb begin
        tgt_raw = $signed({2'b00, pif.sq_ypos}) + TGT_OFS;
        tgt     = tgt_raw;
        if (tgt_raw < 0)
            tgt = '0;
        else if (tgt_raw > Y_MAX_S)
            tgt = Y_MAX_S;
        err     = tgt - $signed({2'b00, y_q});
        abs_err = err[TGT_W-1] ? -err : err;
    end

    always_comb begin
        req    = 1'b0;
        req_up = 1'b0;
        if (state == ST_HUMAN) begin
            req    = pif.move_up ^ pif.move_down;
            req_up = pif.move_up;
        end else if (state == ST_AI_TRACK) begin
            req    = (abs_err > DB_S);
            req_up = err[TGT_W-1];
        end

        // A direct reversal restarts the ramp as if this were the first request cycle,
        // so the first step in the new direction lands a full tier-0 period later.
        restart  = (state == ST_HUMAN) && req && prev_req && (req_up != prev_up);
        cnt_base = restart ? '0 : step_cnt;
        run_base = restart ? '0 : run_cnt;
        tier_eff = restart ? 2'd0 : tier_q;

        period_i  = PERIOD0 >> tier_eff;
        step_last = CNT_W'(period_i - 1);
        fire      = req && (cnt_base == step_last);
        at_limit  = req_up ? (y_q == '0) : (y_q == Y_MAX);
        y_step    = req_up ? (y_q - 1'b1) : (y_q + 1'b1);

        // Only executed human steps advance the ramp; AI stays at tier 0.
        run_upd  = run_base;
        tier_upd = tier_eff;
        if (state == ST_HUMAN && fire && !at_limit) begin
            if (run_base == RUN_LAST) begin
                run_upd  = '0;
                tier_upd = (tier_eff == TIER_MAX) ? TIER_MAX : tier_eff + 2'd1;
            end else begin
                run_upd  = run_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            y_q       <= CENTRE;
            tier_q    <= 2'd0;
            step_cnt  <= '0;
            run_cnt   <= '0;
            react_cnt <= '0;
            moving_q  <= 1'b0;
            prev_req  <= 1'b0;
            prev_up   <= 1'b0;
        end else if (pif.reset_game) begin
            state     <= ST_IDLE;
            y_q       <= CENTRE;
            tier_q    <= 2'd0;
            step_cnt  <= '0;
            run_cnt   <= '0;
            react_cnt <= '0;
            moving_q  <= 1'b0;
            prev_req  <= 1'b0;
            prev_up   <= 1'b0;
        end else begin
            state    <= nxt_state;
            moving_q <= 1'b0;
            if (nxt_state != state) begin
                tier_q    <= 2'd0;
                step_cnt  <= '0;
                run_cnt   <= '0;
                react_cnt <= '0;
                prev_req  <= 1'b0;
                prev_up   <= 1'b0;
            end else begin
                prev_req <= req;
                prev_up  <= req_up;
                if (state == ST_AI_WAIT) begin
                    if (toward && !pif.sq_missed)
                        react_cnt <= react_cnt + 1'b1;
                    else
                        react_cnt <= '0;
                end
                if (!req) begin
                    step_cnt <= '0;
                    run_cnt  <= '0;
                    tier_q   <= 2'd0;
                end else if (fire) begin
                    // At a limit the counter still cycles but the run is held.
                    step_cnt <= '0;
                    run_cnt  <= run_upd;
                    tier_q   <= tier_upd;
                    if (!at_limit) begin
                        y_q      <= y_step;
                        moving_q <= 1'b1;
                    end
                end else begin
                    step_cnt <= cnt_base + 1'b1;
                    run_cnt  <= run_base;
                    tier_q   <= tier_eff;
                end
            end
        end
    end

    assign pif.x_pos  = POS_W'(START_X);
    assign pif.y_pos  = y_q;
    assign pif.tier   = tier_q;
    assign pif.moving = moving_q;
endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Purpose: directed self-checking bench for paddle_motion_ctrl (human ramp, clamps, AI, overrides).
// Latency: expectations are counted in clk_0 edges from the cycle a stimulus is applied.
// Backpressure: none; stimulus is applied 1 time unit after each rising edge.
module tb_paddle_motion_ctrl;
    logic clk_0 = 1'b0;
    logic rst   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   y0;
    int   cnt;
    int   ymax;

    paddle_motion_ctrl_if #(.POS_W(10)) pif ();

    paddle_motion_ctrl #(
        .POS_W(10), .V_VIDEO(480), .PDL_HEIGHT(96), .START_X(24),
        .CLK_HZ(1000), .BASE_SPEED(100), .NUM_TIERS(3), .ACCEL_PIX(4),
        .AI_REACT(20), .AI_DEADBAND(4), .TOWARD_DIR(1'b0)
    ) dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .pif   (pif)
    );

    always #5 clk_0 = ~clk_0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_0);
        #1;
    endtask

    function automatic int yv();
        return int'(pif.y_pos);
    endfunction

    function automatic int tv();
        return int'(pif.tier);
    endfunction

    function automatic int mv();
        return int'(pif.moving);
    endfunction

    // Bounded wait for the paddle to reach a given y; the final value is always checked.
    task automatic wait_y(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (yv() == target) break;
            tick(1);
        end
        check_val(tag, yv(), target);
    endtask

    initial begin
        pif.reset_game  = 1'b0;
        pif.mode_choice = 2'd0;
        pif.move_up     = 1'b0;
        pif.move_down   = 1'b0;
        pif.sq_ypos     = 10'd0;
        pif.sq_xveldir  = 1'b1;
        pif.sq_missed   = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        check_val("rst_y", yv(), 192);
        check_val("rst_tier", tv(), 0);
        check_val("rst_moving", mv(), 0);
        check_val("x_pos", int'(pif.x_pos), 24);

        // Human up from centre: tier 0 (10), tier 1 (5), tier 2 (2) cycle spacing.
        pif.mode_choice = 2'd2;
        tick(3);
        pif.move_up = 1'b1;
        tick(9);
        check_val("up_before_first", yv(), 192);
        tick(1);
        check_val("up_first_step", yv(), 191);
        check_val("up_moving_hi", mv(), 1);
        tick(1);
        check_val("up_moving_lo", mv(), 0);
        tick(29);
        check_val("up_y_c40", yv(), 188);
        check_val("up_tier1", tv(), 1);
        tick(4);
        check_val("up_y_c44", yv(), 188);
        tick(1);
        check_val("up_y_c45", yv(), 187);
        tick(15);
        check_val("up_y_c60", yv(), 184);
        check_val("up_tier2", tv(), 2);
        tick(2);
        check_val("up_y_c62", yv(), 183);
        tick(16);
        check_val("up_y_c78", yv(), 175);
        check_val("up_tier_sat", tv(), 2);

        // Direct reversal to down at tier 2.
        pif.move_up   = 1'b0;
        pif.move_down = 1'b1;
        tick(1);
        check_val("rev_tier", tv(), 0);
        tick(8);
        check_val("rev_y_c9", yv(), 175);
        tick(1);
        check_val("rev_y_c10", yv(), 176);
        tick(50);
        check_val("rev_y_c60", yv(), 183);
        check_val("rev_tier_c60", tv(), 2);

        // Both buttons: frozen, ramp cleared.
        pif.move_up = 1'b1;
        tick(1);
        check_val("both_tier", tv(), 0);
        tick(20);
        check_val("both_y", yv(), 183);
        check_val("both_moving", mv(), 0);

        // Down to the bottom clamp.
        pif.move_up = 1'b0;
        wait_y("bottom_reach", 384, 1000);
        tick(1);
        ymax = 0;
        cnt  = 0;
        for (int i = 0; i < 60; i++) begin
            if (yv() > ymax) ymax = yv();
            if (mv() != 0) cnt++;
            tick(1);
        end
        check_val("bottom_max_y", ymax, 384);
        check_val("bottom_moving_cnt", cnt, 0);
        check_val("bottom_tier_held", tv(), 2);

        // reset_game during a tier-2 run.
        pif.move_down = 1'b0;
        pif.move_up   = 1'b1;
        tick(70);
        check_val("rg_pre_tier", tv(), 2);
        pif.reset_game = 1'b1;
        tick(1);
        pif.reset_game = 1'b0;
        check_val("rg_y", yv(), 192);
        check_val("rg_tier", tv(), 0);
        check_val("rg_moving", mv(), 0);

        // Asynchronous reset mid-run, observed before the next edge.
        tick(45);
        check_val("arst_pre_moved", int'(yv() < 192), 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_y", yv(), 192);
        check_val("arst_tier", tv(), 0);
        check_val("arst_moving", mv(), 0);
        pif.move_up = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);

        // AI: reaction delay restarts when the ball turns away mid-wait.
        pif.sq_ypos     = 10'd50;
        pif.sq_xveldir  = 1'b0;
        pif.mode_choice = 2'd1;
        tick(10);
        check_val("ai_wait_y", yv(), 192);
        pif.sq_xveldir = 1'b1;
        tick(2);
        pif.sq_xveldir = 1'b0;
        tick(25);
        check_val("ai_restart_y", yv(), 192);
        wait_y("ai_first_step", 191, 20);
        tick(9);
        check_val("ai_y_p9", yv(), 191);
        tick(1);
        check_val("ai_y_p10", yv(), 190);
        check_val("ai_tier", tv(), 0);

        // sq_missed while tracking: back to waiting, no motion for the reaction time.
        pif.sq_missed = 1'b1;
        tick(1);
        pif.sq_missed = 1'b0;
        y0  = yv();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (yv() != y0) cnt++;
        end
        check_val("miss_frozen_cnt", cnt, 0);

        // Tracking settles inside the deadband: target 50+4-48=6, stop at 10.
        wait_y("ai_settle", 10, 2500);
        tick(40);
        check_val("ai_settled_y", yv(), 10);
        check_val("ai_settled_moving", mv(), 0);

        // Ball at top: target 4-48 clamps to 0, paddle stops at 4.
        pif.sq_ypos = 10'd0;
        wait_y("ai_clamp_reach", 4, 200);
        tick(30);
        check_val("ai_clamp_y", yv(), 4);

        // Hold mode keeps position.
        pif.sq_ypos     = 10'd300;
        pif.mode_choice = 2'd3;
        tick(40);
        check_val("idle_hold_y", yv(), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
